// File: rtl/handshake_arb_if.sv
// Channel/engine handshake bundle for handshake_arb.
// The arbiter takes the slave view; the environment that drives requests and done takes master.
interface handshake_arb_if #(
    parameter int NCH  = 4,
    parameter int ERRW = 8
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]  ready;
    logic            done;
    logic            start;
    logic [CW-1:0]   grant_id;
    logic            busy;
    logic [NCH-1:0]  ack;
    logic            timeout;
    logic [ERRW-1:0] err_cnt;

    modport master (
        output ready, done,
        input  start, grant_id, busy, ack, timeout, err_cnt
    );

    modport slave (
        input  ready, done,
        output start, grant_id, busy, ack, timeout, err_cnt
    );
endinterface

// File: rtl/handshake_arb.sv
// Round-robin start/done handshake controller: NCH requesters share one engine,
// with an optional WAIT timeout that aborts the transaction and counts errors.
module handshake_arb #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 256,
    parameter int ERRW    = 8
) (
    input  logic            clk,
    input  logic            rst_l,
    handshake_arb_if.slave  bus
);
    localparam int CW = $clog2(NCH);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   last_q, last_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            abort_q, abort_d;
    logic [ERRW-1:0] err_q, err_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic [NCH-1:0]  ack_q, ack_d;
    logic            timeout_q, timeout_d;

    logic            found;
    logic [CW-1:0]   pick;
    logic [CW-1:0]   idx;

    // Outputs are computed from the next state so they are registered yet
    // line up with the state they belong to (start high during START, etc.).
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        err_d   = err_q;
        found   = 1'b0;
        pick    = last_q;
        idx     = last_q;

        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = CW'((32'(last_q) + i) % NCH);
            if (!found && bus.ready[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    last_d  = pick;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.done) begin
                    state_d = ACK;
                end else if (TIMEOUT != 0 && cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = ACK;
                    abort_d = 1'b1;
                    if (err_q != '1)
                        err_d = err_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        start_d   = (state_d == START);
        busy_d    = (state_d != IDLE);
        ack_d     = '0;
        if (state_d == ACK)
            ack_d[grant_d] = 1'b1;
        timeout_d = (state_d == ACK) && abort_d;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= CW'(NCH - 1);
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            err_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            err_q     <= err_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.start    = start_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;
    assign bus.ack      = ack_q;
    assign bus.timeout  = timeout_q;
    assign bus.err_cnt  = err_q;
endmodule

// File: tb/tb_handshake_arb.sv
// Scoreboard bench for handshake_arb: one instance with an 8-cycle timeout,
// one with the timeout disabled.
module tb_handshake_arb;
    localparam int NCH  = 4;
    localparam int ERRW = 8;
    localparam int TO   = 8;

    typedef struct packed {
        logic [3:0] ack;
        logic [1:0] gid;
        logic       to;
        logic [7:0] err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    handshake_arb_if #(.NCH(NCH), .ERRW(ERRW)) ifa ();
    handshake_arb_if #(.NCH(NCH), .ERRW(ERRW)) ifb ();

    handshake_arb #(.NCH(NCH), .TIMEOUT(TO), .ERRW(ERRW)) dut_a (
        .clk(clk), .rst_l(rst_l), .bus(ifa.slave)
    );
    handshake_arb #(.NCH(NCH), .TIMEOUT(0), .ERRW(ERRW)) dut_b (
        .clk(clk), .rst_l(rst_l), .bus(ifb.slave)
    );

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [1:0] m_last = 2'd3;
    logic [7:0] m_err  = 8'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
        logic [1:0] c;
        for (int k = 1; k <= NCH; k++) begin
            c = last + 2'(k);
            if (req[c]) return c;
        end
        return last;
    endfunction

    // Every ack/timeout pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_l && (ifa.ack != '0 || ifa.timeout)) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'({ifa.timeout, ifa.ack}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ack",      32'(ifa.ack),      32'(mon_e.ack));
                check("ack_gid",  32'(ifa.grant_id), 32'(mon_e.gid));
                check("timeout",  32'(ifa.timeout),  32'(mon_e.to));
                check("err_cnt",  32'(ifa.err_cnt),  32'(mon_e.err));
            end
        end
    end

    // dly: WAIT cycles before done (<0 or >=TO means never); dis: pulse done during START.
    task automatic txn(input logic [3:0] req, input int dly, input bit hold, input bit dis);
        exp_t       e;
        int         n;
        logic [1:0] ch;
        n = 0;
        do begin @(negedge clk); n++; end while (ifa.busy && n < 50);
        check("idle_wait", 32'(ifa.busy), 32'd0);
        ifa.ready = req;
        ch     = rr_pick(m_last, req);
        m_last = ch;
        e.ack  = 4'b0001 << ch;
        e.gid  = ch;
        e.to   = (dly < 0 || dly >= TO);
        if (e.to && m_err != 8'hff) m_err++;
        e.err  = m_err;
        sb.push_back(e);

        n = 0;
        do begin @(negedge clk); n++; end while (!ifa.start && n < 10);
        check("start_seen", 32'(ifa.start),    32'd1);
        check("grant_id",   32'(ifa.grant_id), 32'(ch));
        check("busy",       32'(ifa.busy),     32'd1);
        if (!hold) ifa.ready = '0;
        ifa.done = dis;
        @(negedge clk);
        ifa.done = 1'b0;
        check("start_pulse", 32'(ifa.start), 32'd0);
        if (dis) begin
            check("done_in_start_ack",  32'(ifa.ack),  32'd0);
            check("done_in_start_busy", 32'(ifa.busy), 32'd1);
        end
        if (dly >= 0 && dly < TO) begin
            repeat (dly) @(negedge clk);
            ifa.done = 1'b1;
        end
        n = 0;
        do begin @(negedge clk); ifa.done = 1'b0; n++; end while (ifa.ack == '0 && n < TO + 10);
        check("ack_seen", 32'(ifa.ack != '0), 32'd1);
        if (e.to) check("to_latency", 32'(n), 32'(TO));
        else      check("done_latency", 32'(n), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;
        ifa.ready = '0; ifa.done = 1'b0;
        ifb.ready = '0; ifb.done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",  32'(ifa.busy),     32'd0);
        check("rst_start", 32'(ifa.start),    32'd0);
        check("rst_gid",   32'(ifa.grant_id), 32'd0);
        rst_l = 1'b1;
        @(negedge clk);
        check("rel_busy", 32'(ifa.busy),    32'd0);
        check("rel_err",  32'(ifa.err_cnt), 32'd0);

        // all channels held: grants rotate 0,1,2,3,0
        for (int i = 0; i < 4; i++) txn(4'b1111, 0, 1'b1, 1'b0);
        txn(4'b1111, 0, 1'b0, 1'b0);
        // single requester back-to-back, then fairness between two
        txn(4'b0001, 2, 1'b0, 1'b0);
        txn(4'b0001, 2, 1'b0, 1'b0);
        txn(4'b0011, 1, 1'b0, 1'b0);
        txn(4'b0011, 1, 1'b0, 1'b0);
        // done on the last WAIT cycle wins over timeout; done during START ignored
        txn(4'b0100, TO - 1, 1'b0, 1'b1);
        // timeout, then saturation of err_cnt
        txn(4'b1000, -1, 1'b0, 1'b0);
        for (int i = 0; i < 299; i++) txn(4'b0001 << (i % 4), -1, 1'b0, 1'b0);
        check("err_sat", 32'(ifa.err_cnt), 32'd255);

        // reset mid-WAIT aborts silently
        n = 0;
        do begin @(negedge clk); n++; end while (ifa.busy && n < 50);
        ifa.ready = 4'b0100;
        n = 0;
        do begin @(negedge clk); n++; end while (!ifa.start && n < 10);
        ifa.ready = '0;
        repeat (3) @(negedge clk);
        rst_l = 1'b0;
        #1;
        check("arst_busy",    32'(ifa.busy),     32'd0);
        check("arst_start",   32'(ifa.start),    32'd0);
        check("arst_ack",     32'(ifa.ack),      32'd0);
        check("arst_timeout", 32'(ifa.timeout),  32'd0);
        check("arst_gid",     32'(ifa.grant_id), 32'd0);
        check("arst_err",     32'(ifa.err_cnt),  32'd0);
        repeat (2) @(negedge clk);
        rst_l  = 1'b1;
        m_last = 2'd3;
        m_err  = 8'd0;
        txn(4'b1010, 1, 1'b0, 1'b0);

        // timeout disabled: engine may take arbitrarily long
        ifb.ready = 4'b0001;
        n = 0;
        do begin @(negedge clk); n++; end while (!ifb.start && n < 10);
        check("to0_start", 32'(ifb.start), 32'd1);
        ifb.ready = '0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!ifb.busy || ifb.timeout || ifb.ack != '0) bad++;
        end
        check("to0_hold", 32'(bad), 32'd0);
        ifb.done = 1'b1;
        @(negedge clk);
        ifb.done = 1'b0;
        check("to0_ack",     32'(ifb.ack),     32'd1);
        check("to0_timeout", 32'(ifb.timeout), 32'd0);
        check("to0_err",     32'(ifb.err_cnt), 32'd0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
